// File: rtl/bch15_pkg.sv
// Shared constants, FSM state type and parity helper for the BCH(15,5) t=3 encoder.
package bch15_pkg;

    localparam int          BCH_N      = 15;
    localparam int          BCH_K      = 5;
    localparam int          BCH_PAR    = 10;
    localparam logic [10:0] BCH_G_POLY = 11'h537;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bch_state_e;

    // One step of the division-by-g(x) register; g_low is g(x) without its x^10 term.
    function automatic logic [9:0] lfsr_step(input logic [9:0] lfsr,
                                             input logic       din,
                                             input logic [9:0] g_low);
        logic fb;
        fb = din ^ lfsr[9];
        return {lfsr[8:0], 1'b0} ^ (fb ? g_low : 10'd0);
    endfunction

endpackage

// File: rtl/bch15_lfsr.sv
// 10-bit parity register computing (msg(x)*x^10) mod g(x), one message bit per enabled cycle.
module bch15_lfsr
    import bch15_pkg::*;
#(
    parameter logic [10:0] G_POLY = BCH_G_POLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       din,
    output logic [9:0] parity
);

    logic [9:0] parity_r;

    // Parity register: cleared at word start, advanced once per message bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_r <= 10'd0;
        end else if (clr) begin
            parity_r <= 10'd0;
        end else if (shift_en) begin
            parity_r <= lfsr_step(parity_r, din, G_POLY[9:0]);
        end else begin
            parity_r <= parity_r;
        end
    end

    assign parity = parity_r;

endmodule

// File: rtl/bch15_encoder.sv
// Systematic BCH(15,5) encoder: cw[14:10]=msg, cw[9:0]=parity, one word per 7 cycles.
// Optional BCH15_ENC_ERR_INJECT_EN adds err_mask, XORed into cw to stress the decoder.
module bch15_encoder
    import bch15_pkg::*;
#(
    parameter logic [10:0] G_POLY = BCH_G_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  msg,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic [14:0] cw,
    output logic        cw_valid,
    input  logic        cw_ready,
`ifdef BCH15_ENC_ERR_INJECT_EN
    input  logic [14:0] err_mask,
`endif
    output logic        busy
);

    bch_state_e  state_r;
    bch_state_e  state_s;
    logic [4:0]  msg_r;
    logic [2:0]  cnt_r;
    logic [14:0] cw_r;
    logic        cw_valid_r;
    logic [9:0]  parity_s;
    logic        bit_s;
    logic        accept_s;
    logic        shift_en_s;
    logic        last_s;
    logic        release_s;
    logic [14:0] err_s;

    assign bit_s = msg_r[3'd4 - cnt_r];

    bch15_lfsr #(.G_POLY(G_POLY)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept_s),
        .shift_en (shift_en_s),
        .din      (bit_s),
        .parity   (parity_s)
    );

`ifdef BCH15_ENC_ERR_INJECT_EN
    logic [14:0] err_mask_r;

    // Error mask travels with the message so it cannot change mid-word.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_mask_r <= 15'd0;
        end else if (accept_s) begin
            err_mask_r <= err_mask;
        end else begin
            err_mask_r <= err_mask_r;
        end
    end

    assign err_s = err_mask_r;
`else
    assign err_s = 15'd0;
`endif

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        shift_en_s = 1'b0;
        last_s     = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (msg_valid) begin
                    state_s  = SHIFT;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                shift_en_s = 1'b1;
                if (cnt_r == 3'd4) begin
                    state_s = DONE;
                    last_s  = 1'b1;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (cw_ready) begin
                    state_s   = IDLE;
                    release_s = 1'b1;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, message capture, bit counter and output word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            msg_r      <= 5'd0;
            cnt_r      <= 3'd0;
            cw_r       <= 15'd0;
            cw_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                msg_r <= msg;
                cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                cnt_r <= cnt_r + 3'd1;
            end
            // The last bit is folded in here so cw is ready on the same edge as DONE.
            if (last_s) begin
                cw_r       <= {msg_r, lfsr_step(parity_s, bit_s, G_POLY[9:0])} ^ err_s;
                cw_valid_r <= 1'b1;
            end else if (release_s) begin
                cw_valid_r <= 1'b0;
            end
        end
    end

    assign msg_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign cw        = cw_r;
    assign cw_valid  = cw_valid_r;

endmodule

// File: tb/tb_bch15_encoder.sv
// Directed self-checking bench for bch15_encoder; define BCH15_ENC_ERR_INJECT_EN to cover err_mask.
module tb_bch15_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  msg = 5'd0;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [14:0] cw;
    logic        cw_valid;
    logic        cw_ready = 1'b0;
    logic        busy;
`ifdef BCH15_ENC_ERR_INJECT_EN
    logic [14:0] err_mask = 15'd0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bch15_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .msg       (msg),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .cw        (cw),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
`ifdef BCH15_ENC_ERR_INJECT_EN
        .err_mask  (err_mask),
`endif
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Independent reference: long division of msg(x)*x^10 by g(x).
    function automatic logic [14:0] enc_model(input logic [4:0] m);
        logic [14:0] r;
        logic [14:0] g;
        r = {m, 10'd0};
        g = 15'h0537;
        for (int i = 14; i >= 10; i--) begin
            if (r[i]) r = r ^ (g << (i - 10));
        end
        return {m, r[9:0]};
    endfunction

    function automatic logic [3:0] gf_alpha(input int e);
        logic [4:0] a;
        a = 5'd1;
        for (int k = 0; k < (e % 15); k++) begin
            a = a << 1;
            if (a[4]) a = a ^ 5'b10011;
        end
        return a[3:0];
    endfunction

    function automatic logic [3:0] syndrome(input logic [14:0] r, input int j);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (r[i]) s = s ^ gf_alpha(i * j);
        end
        return s;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        tick();
        check_eq("rst_cw", 32'(cw), 32'h0);
        check_eq("rst_cw_valid", 32'(cw_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_msg_ready", 32'(msg_ready), 32'h1);
        rst = 1'b0;
    endtask

    // Offer m once msg_ready is high, then count edges (acceptance edge = 1) until cw_valid.
    task automatic encode(input logic [4:0] m, output logic [14:0] got, output int lat);
        int w;
        w = 0;
        while (!msg_ready && w < 20) begin
            tick();
            w++;
        end
        check_eq("ready_wait", 32'(msg_ready), 32'h1);
        msg = m;
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        msg = ~m;
        check_eq("busy_after_accept", 32'({busy, msg_ready}), 32'h2);
        lat = 1;
        while (!cw_valid && lat < 16) begin
            tick();
            lat++;
        end
        got = cw;
    endtask

    task automatic release_cw(input logic [14:0] held);
        cw_ready = 1'b1;
        tick();
        cw_ready = 1'b0;
        check_eq("release_valid", 32'(cw_valid), 32'h0);
        check_eq("release_ready", 32'(msg_ready), 32'h1);
        check_eq("release_cw_hold", 32'(cw), 32'(held));
    endtask

    logic [4:0]  vec_msg [4] = '{5'b00001, 5'b10000, 5'b11111, 5'b00010};
    logic [14:0] vec_cw  [4] = '{15'h0537, 15'h429B, 15'h7FFF, 15'h0A6E};

    initial begin
        logic [14:0] got;
        int          lat;
        int          bad_cw, bad_valid, bad_ready;
        int          idx, last_acc;
        logic        accepted;
        logic [14:0] got_q[$];

        do_reset();

        for (int v = 0; v < 4; v++) begin
            encode(vec_msg[v], got, lat);
            check_eq($sformatf("cw_%0h", vec_msg[v]), 32'(got), 32'(vec_cw[v]));
            check_eq("latency", 32'(lat), 32'd6);
            release_cw(vec_cw[v]);
        end

        // Zero message, downstream stalled, new offers must be ignored.
        encode(5'd0, got, lat);
        check_eq("cw_zero", 32'(got), 32'h0);
        bad_cw = 0; bad_valid = 0; bad_ready = 0;
        msg = 5'b10101;
        msg_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cw !== 15'h0) bad_cw++;
            if (cw_valid !== 1'b1) bad_valid++;
            if (msg_ready !== 1'b0) bad_ready++;
        end
        msg_valid = 1'b0;
        check_eq("stall_cw_stable", 32'(bad_cw), 32'd0);
        check_eq("stall_valid_stable", 32'(bad_valid), 32'd0);
        check_eq("stall_ready_low", 32'(bad_ready), 32'd0);
        release_cw(15'h0);
        cw_ready = 1'b1;
        tick();
        tick();
        cw_ready = 1'b0;
        check_eq("ready_no_valid", 32'({cw_valid, busy, msg_ready}), 32'h1);

        // Reset during the third SHIFT cycle drops the word.
        msg = 5'b00001;
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midreset_state", 32'({cw_valid, busy, msg_ready}), 32'h1);
        check_eq("midreset_cw", 32'(cw), 32'h0);
        bad_valid = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (cw_valid !== 1'b0) bad_valid++;
        end
        check_eq("midreset_no_valid", 32'(bad_valid), 32'd0);
        encode(5'b00001, got, lat);
        check_eq("after_reset_cw", 32'(got), 32'h0537);

        // Reset wins over a same-cycle handshake in DONE.
        cw_ready = 1'b1;
        msg_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cw_ready = 1'b0;
        msg_valid = 1'b0;
        check_eq("done_reset", 32'({cw_valid, busy, msg_ready}), 32'h1);
        check_eq("done_reset_cw", 32'(cw), 32'h0);

        // All 32 messages back-to-back.
        cw_ready = 1'b1;
        idx = 0;
        last_acc = -1;
        for (int c = 0; c < 400 && got_q.size() < 32; c++) begin
            if (msg_ready && idx < 32) begin
                msg = idx[4:0];
                msg_valid = 1'b1;
            end else begin
                msg = 5'h1F;
                msg_valid = 1'b0;
            end
            accepted = msg_ready && msg_valid;
            tick();
            if (accepted) begin
                if (last_acc >= 0) check_eq("b2b_period", 32'(c - last_acc), 32'd7);
                last_acc = c;
                idx++;
            end
            if (cw_valid) got_q.push_back(cw);
        end
        cw_ready = 1'b0;
        msg_valid = 1'b0;
        check_eq("b2b_count", 32'(got_q.size()), 32'd32);
        for (int k = 0; k < got_q.size(); k++) begin
            check_eq($sformatf("syn_%0d", k),
                     32'({syndrome(got_q[k], 1), syndrome(got_q[k], 3), syndrome(got_q[k], 5)}), 32'h0);
            check_eq($sformatf("dec_%0d", k), 32'(got_q[k][14:10]), 32'(k));
            check_eq($sformatf("model_%0d", k), 32'(got_q[k]), 32'(enc_model(5'(k))));
        end

`ifdef BCH15_ENC_ERR_INJECT_EN
        tick();
        err_mask = 15'h0001;
        encode(5'b00001, got, lat);
        check_eq("err_inject", 32'(got), 32'h0536);
        err_mask = 15'h0000;
        release_cw(15'h0536);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bch15_encoder.md
BCH15_ENCODER -- requirements
Module: bch15_encoder

Interface
REQ-001 The block SHALL have parameter G_POLY, default 11'h537 (x^10+x^8+x^5+x^4+x^2+x+1), giving the BCH(15,5) t=3 generator over GF(2), primitive x^4+x+1.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 The block SHALL have port msg, input, 5, message bits; msg[4] is the coefficient of x^14.
REQ-005 The block SHALL have port msg_valid, input, 1, meaning msg is offered.
REQ-006 The block SHALL have port msg_ready, output, 1, meaning the encoder accepts msg this cycle.
REQ-007 The block SHALL have port cw, output, 15, the codeword; cw[i] is the coefficient of x^i, matching decoder input r[i].
REQ-008 The block SHALL have port cw_valid, output, 1, meaning cw is held valid.
REQ-009 The block SHALL have port cw_ready, input, 1, meaning the downstream accepts cw.
REQ-010 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 The encoding SHALL be systematic: cw[14:10]=msg, cw[9:0]=(msg(x)*x^10) mod g(x).
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 msg_ready SHALL equal (state==IDLE), combinationally from state only.
REQ-014 In IDLE, an edge with msg_valid=1 SHALL capture msg, clear the 10-bit parity LFSR and the 3-bit counter, and enter SHIFT.
REQ-015 In SHIFT, the block SHALL feed one message bit per cycle, MSB first: feedback=bit^lfsr[9]; lfsr=(lfsr<<1)^(feedback ? G_POLY[9:0] : 0).
REQ-016 After exactly 5 SHIFT cycles (counter 0..4), the block SHALL register cw, enter DONE and assert cw_valid, 6 clk edges after the acceptance edge.
REQ-017 In DONE, cw and cw_valid SHALL hold stable until an edge with cw_ready=1, then the block SHALL enter IDLE, deassert cw_valid, and leave cw unchanged.
REQ-018 msg_valid SHALL be ignored outside IDLE; no message is buffered.
REQ-019 A cw_ready=1 while cw_valid=0 SHALL have no effect.
REQ-020 Maximum throughput SHALL be one codeword per 7 cycles.
REQ-021 msg is sampled only on the acceptance edge; later changes to msg SHALL not affect the codeword in flight.

Reset
REQ-022 When rst=1 at an edge, the block SHALL enter IDLE and clear the LFSR, counter, captured message and cw to 0, and set cw_valid=0, busy=0 and msg_ready=1 in the next cycle.
REQ-023 A reset in SHIFT or DONE SHALL discard the word in flight with no cw_valid pulse; rst SHALL override any handshake in the same cycle.

Configuration
REQ-024 Macro BCH15_ENC_ERR_INJECT_EN: when defined, the block SHALL add input err_mask[14:0], capture it with msg on the acceptance edge, and output cw as codeword^err_mask to stress the decoder.
REQ-025 When BCH15_ENC_ERR_INJECT_EN is undefined, err_mask SHALL be absent and cw SHALL be the pure codeword.

Structure
REQ-026 Package bch15_pkg SHALL hold BCH_N=15, BCH_K=5, BCH_PAR=10, the default G_POLY and the FSM state enumeration typedef.
REQ-027 Sub-module bch15_lfsr SHALL hold the 10-bit parity register with ports clk, rst, clr, shift_en, din and parity[9:0].

Verification
REQ-028 The bench SHALL check: rst, then msg=5'b00001 accepted -> cw=15'h0537 with cw_valid rising exactly 6 edges after acceptance.
REQ-029 The bench SHALL check: msg=5'b10000 -> cw=15'h429B; and msg=5'b11111 -> cw=15'h7FFF.
REQ-030 The bench SHALL check: msg=0 -> cw=0; with cw_ready held low for 20 cycles, cw and cw_valid stay stable, msg_ready stays 0, and a new msg_valid is ignored.
REQ-031 The bench SHALL check: rst asserted in the 3rd SHIFT cycle -> no cw_valid, IDLE next cycle with cw=0; the next msg=5'b00001 still gives 15'h0537.
REQ-032 The bench SHALL check all 32 messages back-to-back with cw_ready=1: each cw's syndromes S1, S3 and S5 over GF(16) are zero, and the decoder output equals the input.
REQ-033 With BCH15_ENC_ERR_INJECT_EN defined, the bench SHALL check: msg=5'b00001 with err_mask=15'h0001 -> cw=15'h0536.
